// File: rtl/uart_tx.sv
// UART transmitter: pops one word from the upstream FIFO and shifts it out as start/data/[parity]/stop.
// Latency: pop strobe in the IDLE cycle, start bit on tx_o the next cycle; frame lasts (1+DataBits+ParityEn+StopBits)*16*ClkDiv clocks.
// Backpressure: pops only from IDLE, at most once per frame; fifo_empty_i is ignored while a frame is in progress.
module uart_tx #(
  parameter int DataBits = 8,
  parameter int ClkDiv   = 27,
  parameter int StopBits = 1,
  parameter int ParityEn = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                fifo_empty_i,
  input  logic [DataBits-1:0] fifo_data_i,
  output logic                fifo_rd_o,
  output logic                tx_o,
  output logic                busy_o
);

  localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int BitW = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [3:0]          tick_q, tick_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                tick;
  logic                bit_done;
  logic                pop;

  // Oversample tick, end-of-bit strobe and pop request; the divider only runs inside a frame.
  always_comb begin
    tick     = (state_q != IDLE) && (div_q == DivW'(ClkDiv - 1));
    bit_done = tick && (tick_q == 4'd15);
    pop      = (state_q == IDLE) && !fifo_empty_i;
  end

  // Pop is combinational so the FIFO sees it in the same cycle the word is loaded; masked in reset.
  assign fifo_rd_o = rst_i && pop;
  assign tx_o      = tx_q;
  assign busy_o    = busy_q;

  // Divider and tick counter; both held at zero in IDLE so each frame starts phase-aligned.
  always_comb begin
    div_d  = div_q;
    tick_d = tick_q;
    if (state_q == IDLE) begin
      div_d  = '0;
      tick_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + DivW'(1);
      if (tick) begin
        tick_d = tick_q + 4'd1;
      end
    end
  end

  // Frame sequencing, shift register and bit counting.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = fifo_data_i;
          par_d   = ^fifo_data_i;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_q == BitW'(DataBits - 1)) begin
            bit_d   = '0;
            state_d = (ParityEn != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (bit_q == BitW'(StopBits - 1)) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and busy are computed from the next state so the registered outputs line up with state_q.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (8N1 and 8E2, both ClkDiv=2) fed by behavioural FIFOs.
// Expected words are queued when written and compared when decoded off the serial line.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: 8 data, no parity, 1 stop.  Instance B: 8 data, even parity, 2 stop.
  logic       empty_a = 1'b1, empty_b = 1'b1;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       rd_a, rd_b, tx_a, tx_b, busy_a, busy_b;

  uart_tx #(.DataBits(8), .ClkDiv(2), .StopBits(1), .ParityEn(0)) u_a (
    .clk_i(clk), .rst_i(rst_n), .fifo_empty_i(empty_a), .fifo_data_i(data_a),
    .fifo_rd_o(rd_a), .tx_o(tx_a), .busy_o(busy_a));

  uart_tx #(.DataBits(8), .ClkDiv(2), .StopBits(2), .ParityEn(1)) u_b (
    .clk_i(clk), .rst_i(rst_n), .fifo_empty_i(empty_b), .fifo_data_i(data_b),
    .fifo_rd_o(rd_b), .tx_o(tx_b), .busy_o(busy_b));

  // Write buffers filled by the stimulus; the FIFO processes below consume them.
  logic [7:0] wbuf_a[64];
  logic [7:0] wbuf_b[64];
  int wr_n_a = 0, wr_n_b = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  // FIFO model A: a pop seen at one negedge is consumed at the following negedge,
  // i.e. after the DUT has acted on it at the posedge in between.
  logic [7:0] fq_a[$];
  logic [7:0] junk_a;
  int taken_a = 0, pops_a = 0, pwe_a = 0;
  int pt_a[$];
  bit pend_a = 1'b0;
  always @(negedge clk) begin
    if (pend_a && fq_a.size() > 0) junk_a = fq_a.pop_front();
    while (taken_a < wr_n_a) begin
      fq_a.push_back(wbuf_a[taken_a]);
      taken_a++;
    end
    empty_a = (fq_a.size() == 0);
    data_a  = empty_a ? 8'h00 : fq_a[0];
    #1;
    pend_a = rd_a;
    if (rd_a) begin
      pops_a++;
      pt_a.push_back(cyc);
      if (empty_a) pwe_a++;
    end
  end

  // FIFO model B, same behaviour.
  logic [7:0] fq_b[$];
  logic [7:0] junk_b;
  int taken_b = 0, pops_b = 0, pwe_b = 0;
  int pt_b[$];
  bit pend_b = 1'b0;
  always @(negedge clk) begin
    if (pend_b && fq_b.size() > 0) junk_b = fq_b.pop_front();
    while (taken_b < wr_n_b) begin
      fq_b.push_back(wbuf_b[taken_b]);
      taken_b++;
    end
    empty_b = (fq_b.size() == 0);
    data_b  = empty_b ? 8'h00 : fq_b[0];
    #1;
    pend_b = rd_b;
    if (rd_b) begin
      pops_b++;
      pt_b.push_back(cyc);
      if (empty_b) pwe_b++;
    end
  end

  task automatic push_a(input logic [7:0] d, input bit expect_it);
    wbuf_a[wr_n_a] = d;
    wr_n_a++;
    if (expect_it) exp_a.push_back(d);
  endtask

  task automatic push_b(input logic [7:0] d);
    wbuf_b[wr_n_b] = d;
    wr_n_b++;
    exp_b.push_back(d);
  endtask

  // Serial receiver: finds a start bit, samples each bit at its centre (32 clocks per bit).
  task automatic rx(input bit sel, output logic [7:0] d, output logic p,
                    output bit frame_ok, output int t0, output bit to);
    int n;
    d = 8'h00; p = 1'b0; frame_ok = 1'b1; t0 = 0; to = 1'b0;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk); #2;
      if ((sel ? tx_b : tx_a) === 1'b0) break;
    end
    if (n == 3000) begin
      to = 1'b1;
      return;
    end
    t0 = cyc;
    repeat (16) @(negedge clk);
    #2;
    if ((sel ? tx_b : tx_a) !== 1'b0) frame_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (32) @(negedge clk);
      #2;
      d[i] = sel ? tx_b : tx_a;
    end
    if (sel) begin
      repeat (32) @(negedge clk);
      #2;
      p = tx_b;
    end
    for (int s = 0; s < (sel ? 2 : 1); s++) begin
      repeat (32) @(negedge clk);
      #2;
      if ((sel ? tx_b : tx_a) !== 1'b1) frame_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #2;
    n_vec++; if (tx_a !== 1'b1)   begin n_err++; $display("FAIL reset_tx_a: got %b want 1", tx_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    n_vec++; if (rd_a !== 1'b0)   begin n_err++; $display("FAIL reset_rd_a: got %b want 0", rd_a); end
    n_vec++; if (tx_b !== 1'b1)   begin n_err++; $display("FAIL reset_tx_b: got %b want 1", tx_b); end
    n_vec++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
    n_vec++; if (rd_b !== 1'b0)   begin n_err++; $display("FAIL reset_rd_b: got %b want 0", rd_b); end
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  // One 0x55 frame captured cycle by cycle: pop width, busy width and every bit centre.
  task automatic test_single;
    logic       txs[340];
    int         rdc = 0, busyc = 0;
    logic [7:0] e;
    logic       eb;
    @(posedge clk); #1;
    push_a(8'h55, 1'b1);
    for (int i = 0; i < 340; i++) begin
      @(negedge clk); #2;
      txs[i] = tx_a;
      if (rd_a === 1'b1) rdc++;
      if (busy_a === 1'b1) busyc++;
    end
    n_vec++; if (rdc != 1)   begin n_err++; $display("FAIL single_pop_width: got %0d want 1", rdc); end
    n_vec++; if (busyc != 320) begin n_err++; $display("FAIL single_busy_width: got %0d want 320", busyc); end
    e = exp_a.pop_front();
    for (int k = 0; k < 10; k++) begin
      eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : e[k-1];
      n_vec++;
      if (txs[17 + 32*k] !== eb) begin
        n_err++; $display("FAIL single_bit%0d: got %b want %b", k, txs[17 + 32*k], eb);
      end
    end
    n_vec++; if (empty_a !== 1'b1) begin n_err++; $display("FAIL single_fifo_empty: got %b want 1", empty_a); end
  endtask

  task automatic test_back_to_back;
    int p0 = pt_a.size();
    int pops0 = pops_a;
    int t[3];
    logic [7:0] d, e;
    logic p;
    bit ok, to;
    @(posedge clk); #1;
    push_a(8'hA3, 1'b1); push_a(8'h0F, 1'b1); push_a(8'hFF, 1'b1);
    for (int f = 0; f < 3; f++) begin
      rx(1'b0, d, p, ok, t[f], to);
      e = exp_a.pop_front();
      n_vec++;
      if (to) begin n_err++; $display("FAIL b2b_timeout%0d: no start bit, want %h", f, e); end
      else if (d !== e || !ok) begin
        n_err++; $display("FAIL b2b_data%0d: got %h framing_ok=%0d want %h framing_ok=1", f, d, ok, e);
      end
    end
    n_vec++; if (pops_a - pops0 != 3) begin n_err++; $display("FAIL b2b_pops: got %0d want 3", pops_a - pops0); end
    for (int f = 1; f < 3; f++) begin
      n_vec++;
      if (pt_a[p0+f] - pt_a[p0+f-1] != 321) begin
        n_err++; $display("FAIL b2b_pop_gap%0d: got %0d want 321", f, pt_a[p0+f] - pt_a[p0+f-1]);
      end
      n_vec++;
      if (t[f] - t[f-1] != 321) begin
        n_err++; $display("FAIL b2b_start_gap%0d: got %0d want 321", f, t[f] - t[f-1]);
      end
    end
  endtask

  task automatic test_parity;
    int p0 = pt_b.size();
    int pops0 = pops_b;
    int t[2];
    logic [7:0] d, e;
    logic p;
    bit ok, to;
    @(posedge clk); #1;
    push_b(8'h07); push_b(8'h03);
    for (int f = 0; f < 2; f++) begin
      rx(1'b1, d, p, ok, t[f], to);
      e = exp_b.pop_front();
      n_vec++;
      if (to) begin n_err++; $display("FAIL par_timeout%0d: no start bit, want %h", f, e); end
      else begin
        if (d !== e || !ok) begin
          n_err++; $display("FAIL par_data%0d: got %h framing_ok=%0d want %h framing_ok=1", f, d, ok, e);
        end
        n_vec++;
        if (p !== ^e) begin n_err++; $display("FAIL par_bit%0d: got %b want %b", f, p, ^e); end
      end
    end
    n_vec++; if (pops_b - pops0 != 2) begin n_err++; $display("FAIL par_pops: got %0d want 2", pops_b - pops0); end
    n_vec++;
    if (t[1] - t[0] != 385) begin n_err++; $display("FAIL par_start_gap: got %0d want 385", t[1] - t[0]); end
    n_vec++;
    if (pt_b[p0+1] - pt_b[p0] != 385) begin
      n_err++; $display("FAIL par_pop_gap: got %0d want 385", pt_b[p0+1] - pt_b[p0]);
    end
  endtask

  task automatic test_idle;
    int bad_a = 0, bad_b = 0;
    repeat (100) @(posedge clk);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #2;
      if (tx_a !== 1'b1 || rd_a !== 1'b0 || busy_a !== 1'b0) bad_a++;
      if (tx_b !== 1'b1 || rd_b !== 1'b0 || busy_b !== 1'b0) bad_b++;
    end
    n_vec++; if (bad_a != 0) begin n_err++; $display("FAIL idle_a: %0d bad cycles want 0", bad_a); end
    n_vec++; if (bad_b != 0) begin n_err++; $display("FAIL idle_b: %0d bad cycles want 0", bad_b); end
  endtask

  // Reset lands mid-DATA between edges; 0xAA is lost, 0x3C must follow cleanly.
  task automatic test_reset_mid;
    int pops0 = pops_a;
    int n, t0;
    logic [7:0] d, e;
    logic p;
    bit ok, to;
    @(posedge clk); #1;
    push_a(8'hAA, 1'b0); push_a(8'h3C, 1'b1);
    for (n = 0; n < 3000; n++) begin
      @(negedge clk); #2;
      if (tx_a === 1'b0) break;
    end
    repeat (96) @(negedge clk);
    #2;
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b want 1", busy_a); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_vec++; if (tx_a !== 1'b1)   begin n_err++; $display("FAIL rstmid_tx: got %b want 1", tx_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy_a); end
    n_vec++; if (rd_a !== 1'b0)   begin n_err++; $display("FAIL rstmid_rd: got %b want 0", rd_a); end
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    rx(1'b0, d, p, ok, t0, to);
    e = exp_a.pop_front();
    n_vec++;
    if (to) begin n_err++; $display("FAIL rstmid_timeout: no start bit, want %h", e); end
    else if (d !== e || !ok) begin
      n_err++; $display("FAIL rstmid_data: got %h framing_ok=%0d want %h framing_ok=1", d, ok, e);
    end
    n_vec++; if (pops_a - pops0 != 2) begin n_err++; $display("FAIL rstmid_pops: got %0d want 2", pops_a - pops0); end
  endtask

  task automatic test_fill16;
    int pops0 = pops_a;
    int pwe0 = pwe_a;
    int t0;
    logic [7:0] d, e;
    logic p;
    bit ok, to;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) push_a(8'($urandom_range(0, 255)), 1'b1);
    for (int f = 0; f < 16; f++) begin
      rx(1'b0, d, p, ok, t0, to);
      e = exp_a.pop_front();
      n_vec++;
      if (to) begin n_err++; $display("FAIL fill_timeout%0d: no start bit, want %h", f, e); end
      else if (d !== e || !ok) begin
        n_err++; $display("FAIL fill_data%0d: got %h framing_ok=%0d want %h framing_ok=1", f, d, ok, e);
      end
    end
    repeat (40) @(posedge clk);
    #2;
    n_vec++; if (pops_a - pops0 != 16) begin n_err++; $display("FAIL fill_pops: got %0d want 16", pops_a - pops0); end
    n_vec++; if (pwe_a - pwe0 != 0) begin n_err++; $display("FAIL fill_pop_when_empty: got %0d want 0", pwe_a - pwe0); end
    n_vec++; if (empty_a !== 1'b1) begin n_err++; $display("FAIL fill_fifo_empty: got %b want 1", empty_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL fill_busy_end: got %b want 0", busy_a); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_parity;
    test_idle;
    test_reset_mid;
    test_fill16;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
